// File: rtl/secuenciador_colores_if.sv
// Control interface of the colour sequencer: raw user/VGA inputs in,
// current permutation mode and its status strobes out.
interface secuenciador_colores_if;
  logic       boton;
  logic       auto_en;
  logic       vblank;
  logic [1:0] modo;
  logic       impulso;
  logic       pendiente;

  modport master (
    output boton,
    output auto_en,
    output vblank,
    input  modo,
    input  impulso,
    input  pendiente
  );

  modport slave (
    input  boton,
    input  auto_en,
    input  vblank,
    output modo,
    output impulso,
    output pendiente
  );
endinterface

// File: rtl/secuenciador_colores.sv
// Colour permutation sequencer: a debounced button or a periodic timer requests
// a mode advance, which is applied only on a vertical-blank rising edge.
module secuenciador_colores #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 50000000,
  parameter int unsigned NUM_MODES       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  secuenciador_colores_if.slave  bus
);

  localparam int unsigned DEB_W  = 20;
  localparam int unsigned AUTO_W = 26;
  localparam int unsigned MODO_W = 2;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [MODO_W-1:0] MODO_LAST = MODO_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ESPERA = 2'd1,
    APLICA = 2'd2
  } estado_t;

  logic [1:0]        sync_b;
  logic [1:0]        sync_a;
  logic [1:0]        sync_v;
  logic              v_prev;
  logic              b_s;
  logic              a_s;
  logic              v_s;
  logic              v_rise;

  logic              deb_nivel;
  logic [DEB_W-1:0]  deb_cnt;
  logic              press_ev;

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_ev;

  logic              ev;
  estado_t           estado;
  logic              tardio;
  logic [MODO_W-1:0] modo_q;
  logic              impulso_q;
  logic              pendiente_q;

  assign b_s    = sync_b[1];
  assign a_s    = sync_a[1];
  assign v_s    = sync_v[1];
  assign v_rise = v_s & ~v_prev;
  assign ev     = press_ev | auto_ev;

  // Two-flop synchronizers for the asynchronous inputs, plus vblank edge history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_b <= 2'b00;
      sync_a <= 2'b00;
      sync_v <= 2'b00;
      v_prev <= 1'b0;
    end else begin
      sync_b <= {sync_b[0], bus.boton};
      sync_a <= {sync_a[0], bus.auto_en};
      sync_v <= {sync_v[0], bus.vblank};
      v_prev <= v_s;
    end
  end

  // Debounce: accept a new level only after it has been stable long enough
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_nivel <= 1'b0;
      deb_cnt   <= '0;
      press_ev  <= 1'b0;
    end else begin
      press_ev <= 1'b0;
      if (b_s != deb_nivel) begin
        if (deb_cnt == DEB_LAST) begin
          deb_nivel <= b_s;
          deb_cnt   <= '0;
          press_ev  <= b_s;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Auto-advance timer, one event per wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_cnt <= '0;
      auto_ev  <= 1'b0;
    end else if (!a_s) begin
      auto_cnt <= '0;
      auto_ev  <= 1'b0;
    end else if (auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
      auto_ev  <= 1'b1;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
      auto_ev  <= 1'b0;
    end
  end

  // Request FSM; an event seen on the vblank edge cycle re-arms after APLICA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= REPOSO;
      tardio      <= 1'b0;
      modo_q      <= '0;
      impulso_q   <= 1'b0;
      pendiente_q <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          impulso_q <= 1'b0;
          if (ev) begin
            estado      <= ESPERA;
            pendiente_q <= 1'b1;
          end else begin
            pendiente_q <= 1'b0;
          end
        end
        ESPERA: begin
          pendiente_q <= 1'b1;
          if (v_rise) begin
            estado    <= APLICA;
            tardio    <= ev;
            impulso_q <= 1'b1;
            modo_q    <= (modo_q == MODO_LAST) ? '0 : modo_q + MODO_W'(1);
          end else begin
            impulso_q <= 1'b0;
          end
        end
        APLICA: begin
          impulso_q <= 1'b0;
          if (tardio || ev) begin
            estado      <= ESPERA;
            pendiente_q <= 1'b1;
          end else begin
            estado      <= REPOSO;
            pendiente_q <= 1'b0;
          end
        end
        default: begin
          estado      <= REPOSO;
          impulso_q   <= 1'b0;
          pendiente_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.modo      = modo_q;
  assign bus.impulso   = impulso_q;
  assign bus.pendiente = pendiente_q;

endmodule

// File: doc/secuenciador_colores.md
SECUENCIADOR_COLORES -- requirements
Module: secuenciador_colores

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 The block SHALL have parameter AUTO_PERIOD, default 50000000: cycles between automatic advances (1 s at 50 MHz); legal range 2..2^26-1.
REQ-003 The block SHALL have parameter NUM_MODES, default 4: number of colour permutation modes; legal range 2..4.
REQ-004 The block SHALL have port clock, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 resets the block immediately, independent of clock.
REQ-006 The block SHALL have port boton, input, 1 bit: raw pushbutton, asynchronous and bouncing; 1 means pressed.
REQ-007 The block SHALL have port auto_en, input, 1 bit: asynchronous slide switch; 1 enables timed auto-advance.
REQ-008 The block SHALL have port vblank, input, 1 bit: vertical-blank flag from the VGA sync generator; 1 during blanking.
REQ-009 The block SHALL have port modo, output, 2 bits: current colour permutation mode index driven to the colour datapath.
REQ-010 The block SHALL have port impulso, output, 1 bit: one-cycle strobe on every change of modo.
REQ-011 The block SHALL have port pendiente, output, 1 bit: 1 while an advance request waits for vertical blank.

Function
REQ-012 The block SHALL pass boton, auto_en and vblank each through a two-flop synchronizer before any use; in this document b_s, a_s and v_s name the synchronized values.
REQ-013 Debounce: the debounced level SHALL start at 0, and a stability counter SHALL increment while b_s differs from the debounced level and clear to 0 when they match.
REQ-014 When the stability counter reaches DEBOUNCE_CYCLES-1 while b_s still differs, the debounced level SHALL take the value of b_s and the counter SHALL clear to 0.
REQ-015 A press event SHALL be a 0->1 transition of the debounced level; a release SHALL generate no event.
REQ-016 Auto timer: while a_s=0, the auto counter SHALL be held at 0; while a_s=1, it SHALL count 0..AUTO_PERIOD-1 and wrap to 0.
REQ-017 Each wrap of the auto counter SHALL generate one auto event.
REQ-018 FSM state REPOSO: pendiente=0; a press event or auto event SHALL cause a transition to ESPERA.
REQ-019 FSM state ESPERA: pendiente=1; further events SHALL coalesce into the single pending request (no queueing); a 0->1 transition of v_s SHALL cause a transition to APLICA.
REQ-020 FSM state APLICA, exactly one cycle: modo SHALL advance as (modo==NUM_MODES-1) ? 0 : modo+1, and impulso SHALL be 1.
REQ-021 From APLICA, the FSM SHALL go to ESPERA if an event occurred in ESPERA on or after the cycle of the v_s edge, or in APLICA itself; otherwise it SHALL go to REPOSO.
REQ-022 modo SHALL change at most once per vblank rising edge; a v_s level that is already 1 when a request arrives SHALL NOT trigger APLICA, and the block SHALL wait for the next 0->1 transition.
REQ-023 Simultaneous press and auto events in one cycle SHALL count as one request.
REQ-024 impulso SHALL be 0 in all states other than APLICA, and modo SHALL hold its value outside APLICA.
REQ-025 Turning auto_en off while in ESPERA SHALL NOT cancel the pending request.

Reset
REQ-026 While reset=0, the block SHALL force modo=0, impulso=0, pendiente=0, FSM=REPOSO, debounced level=0, all counters=0 and all synchronizer flops=0.
REQ-027 Reset asserted mid-request, including in APLICA, SHALL discard the request; no impulso SHALL be emitted after reset is released until a new event arrives.
REQ-028 After reset deasserts, a boton held at 1 SHALL produce exactly one press event, after synchronizer latency plus DEBOUNCE_CYCLES.

Verification
Directed scenarios use DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, NUM_MODES=4.
REQ-029 Bounce: boton toggles every cycle for 20 cycles, then holds 1, with v_s pulsing -> exactly one request; modo goes 0->1 at the first v_s rise after acceptance, with a single impulso.
REQ-030 Wrap: four accepted presses, each followed by one vblank rise -> modo sequence 1,2,3,0, with four impulso pulses.
REQ-031 Coalesce: three presses, then one vblank rise -> modo advances by exactly 1; pendiente drops to 0 the cycle after APLICA.
REQ-032 Auto: auto_en=1 for 35 cycles with a vblank rise every 5 cycles -> modo advances at the first vblank rise following each of the three wraps (3 advances); auto_en=0 -> modo holds.
REQ-033 Reset in ESPERA: reset=0 for 1 cycle while pendiente=1 -> modo=0 and pendiente=0 at once; the next vblank rise produces no impulso.
REQ-034 NUM_MODES=3: three advances -> modo sequence 1,2,0; the value 3 never appears.
